uno_card_pile: RTL and testbench

- Parametrised card-pile engine: a shuffled draw pile and a discard pile share one DEPTH-entry card memory.
- Draw pile grows upward from index 0; discard pile grows downward from index DEPTH-1.
- Supports multi-card draw requests. When the draw pile empties mid-draw, the discard pile (all but its top card) is recycled, reshuffled with an LFSR Fisher-Yates pass, and the draw continues.
- Sits between the game controller (draw/discard requests) and the player-hand logic (card stream).

---
 rtl/uno_card_pile.sv | 208 ++++++++++++++++++++
 tb/tb_uno_card_pile.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uno_card_pile.sv
// Card-pile engine: draw pile (growing up from 0) and discard pile (growing down from DEPTH-1)
// share one memory; empty draws recycle the discard pile and reshuffle it with an LFSR.
module uno_card_pile #(
  parameter int CARD_W = 6,
  parameter int DEPTH  = 108,
  parameter int IDX_W  = $clog2(DEPTH + 1),
  parameter int LFSR_W = 16,
  parameter int NUM_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_valid,
  input  logic [CARD_W-1:0] i_load_card,
  input  logic              i_shuffle,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_draw_req,
  input  logic [NUM_W-1:0]  i_draw_num,
  input  logic              i_discard_valid,
  input  logic [CARD_W-1:0] i_discard_card,
  output logic              o_ready,
  output logic              o_card_valid,
  output logic [CARD_W-1:0] o_card,
  output logic              o_draw_done,
  output logic              o_short,
  output logic [CARD_W-1:0] o_top,
  output logic [IDX_W-1:0]  o_draw_cnt,
  output logic [IDX_W-1:0]  o_disc_cnt
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO_I   = IDX_W'(2);

  // Right-shift Galois feedback masks for maximal-length sequences.
  function automatic logic [31:0] galoisTaps(input int width);
    logic [31:0] taps;
    case (width)
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      default: taps = 32'h0000_B400;
    endcase
    return taps;
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(galoisTaps(LFSR_W));

  typedef enum logic [1:0] {S_IDLE, S_SHUFFLE, S_DRAW, S_RECYCLE} state_t;

  state_t             r_state;
  logic [CARD_W-1:0]  r_mem [DEPTH];
  logic [IDX_W-1:0]   r_drawCnt;
  logic [IDX_W-1:0]   r_discCnt;
  logic [IDX_W-1:0]   r_idx;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [NUM_W-1:0]   r_pend;
  logic [CARD_W-1:0]  r_card;
  logic [CARD_W-1:0]  r_top;
  logic               r_cardValid;
  logic               r_drawDone;
  logic               r_short;

  logic               w_full;
  logic [LFSR_W-1:0]  w_lfsrNext;
  logic [LFSR_W-1:0]  w_seed;
  logic [IDX_W-1:0]   w_rnd;
  logic [IDX_W-1:0]   w_mirror;
  logic [ADDR_W-1:0]  w_topAddr;
  logic [ADDR_W-1:0]  w_discAddr;
  logic [ADDR_W-1:0]  w_iAddr;
  logic [ADDR_W-1:0]  w_rAddr;
  logic [ADDR_W-1:0]  w_mirAddr;
  logic [CARD_W-1:0]  w_cardI;
  logic [CARD_W-1:0]  w_cardR;
  logic [CARD_W-1:0]  w_cardMir;

  assign w_full     = (r_drawCnt + r_discCnt) == DEPTH_I;
  assign w_lfsrNext = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_seed     = (i_seed == '0) ? LFSR_W'(1) : i_seed;
  assign w_rnd      = r_lfsr[IDX_W-1:0];
  assign w_mirror   = DEPTH_I - ONE_I - r_idx;
  assign w_topAddr  = ADDR_W'(r_drawCnt - ONE_I);
  assign w_discAddr = ADDR_W'(DEPTH_I - ONE_I - r_discCnt);
  assign w_iAddr    = ADDR_W'(r_idx);
  assign w_rAddr    = ADDR_W'(w_rnd);
  assign w_mirAddr  = ADDR_W'(w_mirror);
  assign w_cardI    = r_mem[w_iAddr];
  assign w_cardR    = r_mem[w_rAddr];
  assign w_cardMir  = r_mem[w_mirAddr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_drawCnt   <= '0;
      r_discCnt   <= '0;
      r_idx       <= '0;
      r_lfsr      <= LFSR_W'(1);
      r_pend      <= '0;
      r_card      <= '0;
      r_top       <= '0;
      r_cardValid <= 1'b0;
      r_drawDone  <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_cardValid <= 1'b0;
      r_drawDone  <= 1'b0;
      r_short     <= 1'b0;
      if (r_state != S_IDLE) r_lfsr <= w_lfsrNext;

      case (r_state)
        S_IDLE: begin
          if (i_shuffle) begin
            r_lfsr  <= w_seed;
            r_idx   <= (r_drawCnt > ONE_I) ? r_drawCnt - ONE_I : '0;
            r_state <= S_SHUFFLE;
          end else if (i_draw_req) begin
            r_pend  <= (i_draw_num == '0) ? NUM_W'(1) : i_draw_num;
            r_state <= S_DRAW;
          end else if (i_discard_valid) begin
            if (!w_full) begin
              r_mem[w_discAddr] <= i_discard_card;
              r_discCnt         <= r_discCnt + ONE_I;
              r_top             <= i_discard_card;
            end
          end else if (i_load_valid) begin
            if (!w_full) begin
              r_mem[ADDR_W'(r_drawCnt)] <= i_load_card;
              r_drawCnt                 <= r_drawCnt + ONE_I;
            end
          end
        end

        // Fisher-Yates with rejection: out-of-range random indices just wait for the next LFSR step.
        S_SHUFFLE: begin
          if (r_idx == '0) begin
            r_state <= (r_pend != '0) ? S_DRAW : S_IDLE;
          end else if (w_rnd <= r_idx) begin
            r_mem[w_iAddr] <= w_cardR;
            r_mem[w_rAddr] <= w_cardI;
            r_idx          <= r_idx - ONE_I;
          end
        end

        S_DRAW: begin
          if (r_pend == '0) begin
            r_drawDone <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_drawCnt != '0) begin
            r_card      <= r_mem[w_topAddr];
            r_cardValid <= 1'b1;
            r_drawCnt   <= r_drawCnt - ONE_I;
            r_pend      <= r_pend - NUM_W'(1);
          end else if (r_discCnt > ONE_I) begin
            r_idx   <= '0;
            r_state <= S_RECYCLE;
          end else begin
            r_drawDone <= 1'b1;
            r_short    <= 1'b1;
            r_pend     <= '0;
            r_state    <= S_IDLE;
          end
        end

        // Swapping instead of copying keeps every non-top discard card intact when the
        // source and destination ranges overlap; the top card lives safely in r_top.
        S_RECYCLE: begin
          if (r_idx == r_discCnt - ONE_I) begin
            r_mem[DEPTH-1] <= r_top;
            r_drawCnt      <= r_discCnt - ONE_I;
            r_discCnt      <= ONE_I;
            r_idx          <= (r_discCnt > TWO_I) ? r_discCnt - TWO_I : '0;
            r_state        <= S_SHUFFLE;
          end else begin
            if (r_idx < w_mirror) begin
              r_mem[w_iAddr]   <= w_cardMir;
              r_mem[w_mirAddr] <= w_cardI;
            end
            r_idx <= r_idx + ONE_I;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready      = (r_state == S_IDLE);
  assign o_card_valid = r_cardValid;
  assign o_card       = r_card;
  assign o_draw_done  = r_drawDone;
  assign o_short      = r_short;
  assign o_top        = r_top;
  assign o_draw_cnt   = r_drawCnt;
  assign o_disc_cnt   = r_discCnt;

endmodule

// File: tb/tb_uno_card_pile.sv
// Self-checking bench for uno_card_pile: ordered draws go through an expected-card queue,
// shuffled draws are checked as multisets.
module tb_uno_card_pile;

  // Card width widened so 108 distinct codes fit.
  localparam int CW = 7;
  localparam int IW = 7;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_load_valid;
  logic [CW-1:0] i_load_card;
  logic          i_shuffle;
  logic [15:0]   i_seed;
  logic          i_draw_req;
  logic [2:0]    i_draw_num;
  logic          i_discard_valid;
  logic [CW-1:0] i_discard_card;
  logic          o_ready;
  logic          o_card_valid;
  logic [CW-1:0] o_card;
  logic          o_draw_done;
  logic          o_short;
  logic [CW-1:0] o_top;
  logic [IW-1:0] o_draw_cnt;
  logic [IW-1:0] o_disc_cnt;

  uno_card_pile #(.CARD_W(CW), .DEPTH(108), .LFSR_W(16), .NUM_W(3)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load_valid(i_load_valid), .i_load_card(i_load_card),
    .i_shuffle(i_shuffle), .i_seed(i_seed),
    .i_draw_req(i_draw_req), .i_draw_num(i_draw_num),
    .i_discard_valid(i_discard_valid), .i_discard_card(i_discard_card),
    .o_ready(o_ready), .o_card_valid(o_card_valid), .o_card(o_card),
    .o_draw_done(o_draw_done), .o_short(o_short), .o_top(o_top),
    .o_draw_cnt(o_draw_cnt), .o_disc_cnt(o_disc_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] mDraw[$];
  logic [CW-1:0] expQ[$];
  logic [CW-1:0] gotQ[$];
  int            gotCyc[$];
  int            doneCyc;
  bit            gotDone, gotShort, timedOut;

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_load_valid = 0; i_load_card = '0; i_shuffle = 0; i_seed = '0;
    i_draw_req = 0; i_draw_num = '0; i_discard_valid = 0; i_discard_card = '0;
    i_rst_n = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    mDraw.delete();
    expQ.delete();
    cycle();
  endtask

  task automatic loadCard(input logic [CW-1:0] c);
    i_load_valid = 1; i_load_card = c;
    cycle();
    i_load_valid = 0;
    mDraw.push_back(c);
  endtask

  task automatic discardCard(input logic [CW-1:0] c);
    i_discard_valid = 1; i_discard_card = c;
    cycle();
    i_discard_valid = 0;
  endtask

  task automatic runDraw(input int num, input int maxCyc);
    gotQ.delete(); gotCyc.delete();
    gotDone = 0; gotShort = 0; timedOut = 1; doneCyc = -1;
    i_draw_num = 3'(num); i_draw_req = 1;
    cycle();
    i_draw_req = 0;
    for (int c = 0; c < maxCyc; c++) begin
      cycle();
      if (o_card_valid) begin gotQ.push_back(o_card); gotCyc.push_back(c); end
      if (o_draw_done) begin gotDone = 1; gotShort = o_short; doneCyc = c; timedOut = 0; break; end
    end
  endtask

  task automatic waitIdle(input int maxCyc, output bit ok, output int cards);
    ok = 0; cards = 0;
    for (int c = 0; c < maxCyc; c++) begin
      if (o_ready) begin ok = 1; break; end
      cycle();
      if (o_card_valid) cards++;
    end
  endtask

  task automatic test_reset();
    doReset();
    total++; if (o_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=1", o_ready); end
    total++; if (o_draw_cnt !== '0) begin bad++; $display("[TB] FAIL reset_draw_cnt got=%0d want=0", o_draw_cnt); end
    total++; if (o_disc_cnt !== '0) begin bad++; $display("[TB] FAIL reset_disc_cnt got=%0d want=0", o_disc_cnt); end
    total++; if (o_top !== '0) begin bad++; $display("[TB] FAIL reset_top got=%0h want=0", o_top); end
    total++; if ({o_card_valid, o_draw_done, o_short} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses got=%b want=000", {o_card_valid, o_draw_done, o_short}); end
    total++; if (o_card !== '0) begin bad++; $display("[TB] FAIL reset_card got=%0h want=0", o_card); end
  endtask

  task automatic test_draw_order();
    logic [CW-1:0] e, g;
    doReset();
    loadCard(7'h0A); loadCard(7'h0B); loadCard(7'h0C); loadCard(7'h0D);
    total++; if (o_draw_cnt !== 7'd4) begin bad++; $display("[TB] FAIL load_cnt got=%0d want=4", o_draw_cnt); end
    repeat (2) expQ.push_back(mDraw.pop_back());
    runDraw(2, 20);
    total++; if (timedOut) begin bad++; $display("[TB] FAIL draw2_done got=timeout want=done"); end
    total++; if (gotQ.size() != 2) begin bad++; $display("[TB] FAIL draw2_count got=%0d want=2", gotQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      g = (gotQ.size() > 0) ? gotQ.pop_front() : 'x;
      total++; if (g !== e) begin bad++; $display("[TB] FAIL draw2_card got=%0h want=%0h", g, e); end
    end
    total++; if (gotCyc.size() != 2 || gotCyc[0] != 0 || gotCyc[1] != 1 || doneCyc != 2) begin
      bad++; $display("[TB] FAIL draw2_timing got=%0d cards done@%0d want=cards@0,1 done@2", gotCyc.size(), doneCyc); end
    total++; if (o_draw_cnt !== 7'd2) begin bad++; $display("[TB] FAIL draw2_cnt got=%0d want=2", o_draw_cnt); end
    expQ.push_back(mDraw.pop_back());
    runDraw(0, 20);
    e = expQ.pop_front();
    g = (gotQ.size() == 1) ? gotQ[0] : 'x;
    total++; if (g !== e) begin bad++; $display("[TB] FAIL draw0_card got=%0h n=%0d want=%0h n=1", g, gotQ.size(), e); end
    total++; if (o_draw_cnt !== 7'd1) begin bad++; $display("[TB] FAIL draw0_cnt got=%0d want=1", o_draw_cnt); end
  endtask

  task automatic test_full_shuffle();
    bit ok;
    int cards, tmo, missing, diff;
    int seen[108];
    logic [CW-1:0] allQ[$];
    doReset();
    for (int i = 0; i < 108; i++) loadCard(CW'(i));
    total++; if (o_draw_cnt !== 7'd108) begin bad++; $display("[TB] FAIL full_cnt got=%0d want=108", o_draw_cnt); end
    i_load_valid = 1; i_load_card = 7'h7F; cycle(); i_load_valid = 0;
    total++; if (o_draw_cnt !== 7'd108) begin bad++; $display("[TB] FAIL full_load_drop got=%0d want=108", o_draw_cnt); end
    discardCard(7'h7E);
    total++; if (o_disc_cnt !== '0 || o_top !== '0) begin bad++; $display("[TB] FAIL full_disc_drop got=%0d/%0h want=0/0", o_disc_cnt, o_top); end
    i_seed = 16'hACE1; i_shuffle = 1; cycle(); i_shuffle = 0;
    total++; if (o_ready !== 1'b0) begin bad++; $display("[TB] FAIL shuffle_busy got=%0b want=0", o_ready); end
    waitIdle(20000, ok, cards);
    total++; if (!ok) begin bad++; $display("[TB] FAIL shuffle_idle got=timeout want=idle"); end
    tmo = 0;
    for (int r = 0; r < 27; r++) begin
      runDraw(4, 50);
      if (timedOut) tmo++;
      foreach (gotQ[j]) allQ.push_back(gotQ[j]);
    end
    total++; if (tmo != 0 || allQ.size() != 108) begin bad++; $display("[TB] FAIL deal_count got=%0d timeouts=%0d want=108 timeouts=0", allQ.size(), tmo); end
    foreach (seen[j]) seen[j] = 0;
    diff = 0;
    foreach (allQ[j]) begin
      if (allQ[j] < 108) seen[allQ[j]]++;
      if (allQ[j] !== CW'(107 - j)) diff++;
    end
    missing = 0;
    foreach (seen[j]) if (seen[j] != 1) missing++;
    total++; if (missing != 0) begin bad++; $display("[TB] FAIL deal_unique got=%0d bad codes want=0", missing); end
    total++; if (diff == 0) begin bad++; $display("[TB] FAIL deal_shuffled got=unshuffled order want=permuted"); end
    total++; if (o_draw_cnt !== '0) begin bad++; $display("[TB] FAIL deal_empty got=%0d want=0", o_draw_cnt); end
  endtask

  task automatic test_recycle();
    logic [CW-1:0] e;
    doReset();
    loadCard(7'h21);
    discardCard(7'h31); discardCard(7'h32); discardCard(7'h33);
    total++; if (o_top !== 7'h33 || o_disc_cnt !== 7'd3) begin bad++; $display("[TB] FAIL rc_setup got=%0h/%0d want=33/3", o_top, o_disc_cnt); end
    expQ.push_back(mDraw.pop_back());
    runDraw(3, 3000);
    total++; if (timedOut || gotQ.size() != 3) begin bad++; $display("[TB] FAIL rc_count got=%0d timeout=%0b want=3 timeout=0", gotQ.size(), timedOut); end
    e = expQ.pop_front();
    total++; if (gotQ.size() < 1 || gotQ[0] !== e) begin bad++; $display("[TB] FAIL rc_first got=%0h want=%0h", (gotQ.size() > 0) ? gotQ[0] : 'x, e); end
    total++; if (gotQ.size() != 3 || !((gotQ[1] === 7'h31 && gotQ[2] === 7'h32) || (gotQ[1] === 7'h32 && gotQ[2] === 7'h31))) begin
      bad++; $display("[TB] FAIL rc_recycled got=%0d cards want={31,32}", gotQ.size()); end
    total++; if (gotShort !== 1'b0) begin bad++; $display("[TB] FAIL rc_short got=%0b want=0", gotShort); end
    total++; if (o_top !== 7'h33 || o_disc_cnt !== 7'd1 || o_draw_cnt !== '0) begin
      bad++; $display("[TB] FAIL rc_after got=top%0h disc%0d draw%0d want=top33 disc1 draw0", o_top, o_disc_cnt, o_draw_cnt); end
  endtask

  task automatic test_short();
    doReset();
    discardCard(7'h15);
    runDraw(2, 20);
    total++; if (timedOut || !gotDone) begin bad++; $display("[TB] FAIL short_done got=timeout want=done"); end
    total++; if (gotQ.size() != 0) begin bad++; $display("[TB] FAIL short_cards got=%0d want=0", gotQ.size()); end
    total++; if (gotShort !== 1'b1) begin bad++; $display("[TB] FAIL short_flag got=%0b want=1", gotShort); end
    total++; if (o_disc_cnt !== 7'd1 || o_top !== 7'h15 || o_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL short_after got=disc%0d top%0h rdy%0b want=disc1 top15 rdy1", o_disc_cnt, o_top, o_ready); end
  endtask

  task automatic test_priority();
    bit ok;
    int cards;
    doReset();
    loadCard(7'h41); loadCard(7'h42); loadCard(7'h43);
    i_shuffle = 1; i_seed = 16'h1234; i_draw_req = 1; i_draw_num = 3'd2;
    i_discard_valid = 1; i_discard_card = 7'h44;
    cycle();
    i_shuffle = 0; i_draw_req = 0; i_discard_valid = 0;
    total++; if (o_ready !== 1'b0) begin bad++; $display("[TB] FAIL prio_busy got=%0b want=0", o_ready); end
    discardCard(7'h45);
    waitIdle(3000, ok, cards);
    total++; if (!ok) begin bad++; $display("[TB] FAIL prio_idle got=timeout want=idle"); end
    total++; if (cards != 0) begin bad++; $display("[TB] FAIL prio_nodraw got=%0d cards want=0", cards); end
    total++; if (o_disc_cnt !== '0 || o_top !== '0 || o_draw_cnt !== 7'd3) begin
      bad++; $display("[TB] FAIL prio_counts got=disc%0d top%0h draw%0d want=disc0 top0 draw3", o_disc_cnt, o_top, o_draw_cnt); end
    runDraw(3, 20);
    gotQ.sort();
    total++; if (gotQ.size() != 3 || gotQ[0] !== 7'h41 || gotQ[1] !== 7'h42 || gotQ[2] !== 7'h43) begin
      bad++; $display("[TB] FAIL prio_content got=%0d cards want={41,42,43}", gotQ.size()); end
  endtask

  task automatic test_reset_mid_draw();
    bit seen;
    int events;
    doReset();
    for (int i = 0; i < 5; i++) loadCard(CW'(8'h51 + i));
    i_draw_num = 3'd4; i_draw_req = 1; cycle(); i_draw_req = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin cycle(); if (o_card_valid) seen = 1; end
    total++; if (!seen) begin bad++; $display("[TB] FAIL mid_first got=no card want=card"); end
    #2 i_rst_n = 0;
    #1;
    total++; if (o_card_valid !== 1'b0 || o_draw_cnt !== '0 || o_disc_cnt !== '0) begin
      bad++; $display("[TB] FAIL mid_reset got=v%0b draw%0d disc%0d want=v0 draw0 disc0", o_card_valid, o_draw_cnt, o_disc_cnt); end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    events = 0;
    for (int c = 0; c < 10; c++) begin cycle(); if (o_draw_done || o_card_valid) events++; end
    total++; if (events != 0) begin bad++; $display("[TB] FAIL mid_nodone got=%0d events want=0", events); end
    total++; if (o_ready !== 1'b1 || o_draw_cnt !== '0) begin bad++; $display("[TB] FAIL mid_after got=rdy%0b draw%0d want=rdy1 draw0", o_ready, o_draw_cnt); end
  endtask

  initial begin
    test_reset();
    test_draw_order();
    test_full_shuffle();
    test_recycle();
    test_short();
    test_priority();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
